data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
//  Memory-side responder for the CPU core's data SRAM port (en/we/addr/wdata -> rdata).
//  Serves a word-addressed on-chip RAM plus a small MMIO window (LED, switch, timer, IRQ).
//  Sits between the core's data port and board I/O in the SoC top.
//  Fixed 1-cycle read latency, matching what the core's MEM stage expects.
// PARAMETERS
//  RAM_AW     12            RAM word-address width; depth = 2**RAM_AW words
//  MMIO_BASE  32'hBFAF_0000 MMIO window base; only bits [31:16] are compared
// PORTS
//  clk         in   1   rising-edge clock
//  resetn      in   1   asynchronous active-low reset
//  sram_en     in   1   access request this cycle
//  sram_we     in   4   byte write enables; 4'b0000 with en = read
//  sram_addr   in   32  byte address; bits [1:0] ignored
//  sram_wdata  in   32  write data, byte lanes per sram_we
//  sram_rdata  out  32  read data, valid the cycle after a read request
//  led         out  16  LED register
//  switch_in   in   8   asynchronous board switches
//  timer_irq   out  1   timer compare interrupt, level, sticky until cleared
// BEHAVIOUR
//  Decode: addr[31:16]==MMIO_BASE[31:16] -> MMIO, else RAM word addr[RAM_AW+1:2].
//   Upper RAM bits are ignored, so addresses alias modulo 2**RAM_AW words.
//  RAM: write per byte lane at the edge when en && we!=0. Contents are not reset.
//  Read: on en && we==0, sram_rdata <= selected word at the edge (latency 1).
//   Otherwise sram_rdata holds its value. Write-then-read of the same word on consecutive cycles returns the new data.
//  MMIO offsets (addr[15:0]); unmapped reads return 0, unmapped writes are ignored:
//   0x8000 LED      RW  [15:0], byte lanes 0-1 honoured, upper bits read 0
//   0x8004 SWITCH   RO  {24'b0, switch_sync}, via 2-flop synchronizer (2-cycle lag)
//   0x8010 TIMER    RW  32b free-running, +1 per cycle, wraps 32'hFFFF_FFFF->0
//   0x8014 TIMECMP  RW  32b compare value
//   0x8018 IRQSTAT  R: {31'b0, timer_irq}; any write (any we bit) clears it
//  Byte enables apply to TIMER and TIMECMP.
//  TIMER write that cycle overrides the increment (masked lanes take the old value+1? no: old value).
//  TIMER read returns the value before that edge's increment.
//  IRQ: timer_irq sets on the edge after TIMER==TIMECMP, only if TIMECMP!=0.
//   Set and clear in the same cycle -> set wins (irq stays 1).
//  Reset (async, any time incl. mid-access): sram_rdata=0, led=0, timer=0, timecmp=0,
//   timer_irq=0, sync flops=0; an access in flight is dropped; RAM keeps its contents.
//  sram_addr[1:0] != 0 is not checked; the core guarantees alignment via ALE.
// CONFIGURATION
//  DATA_SRAM_RESP_TIMER_EN defined: TIMER, TIMECMP, IRQSTAT and timer_irq as above.
//  Not defined: no timer logic; offsets 0x8010-0x8018 read 0 and ignore writes;
//   timer_irq tied 0. RAM, LED and SWITCH are unchanged.
// TESTING
//  RAM bytes: write 0x11223344 we=1111 @0x100, then we=0010 data 0xAABBCCDD,
//   read @0x100 -> 0x1122CC44 one cycle after en.
//  Alias: RAM_AW=12, write 0xDEADBEEF @0x0000_0004, read @0x0000_4004 -> 0xDEADBEEF.
//  LED: write 0xFFFF_1234 we=0001 @0xBFAF_8000 -> led=0x0034;
//   read -> 0x0000_0034; switch_in=0xA5 held 3 cycles, read 0x8004 -> 0xA5.
//  Timer IRQ: write TIMECMP=20, TIMER=10 -> timer_irq rises 11 cycles after the TIMER write edge.
//   Write IRQSTAT -> 0 next cycle; clear with TIMER==TIMECMP on the same cycle -> irq stays 1.
//  Reset mid-read: en read of 0x8010 then resetn low before the edge -> sram_rdata=0,
//   led=0, timer=0; RAM word @0x100 still 0x1122CC44 after release.
//  Macro off: write TIMER=5, read 0x8010 -> 0; timer_irq stays 0 for 1000 cycles.

Source files
------------

// File: rtl/data_sram_responder_if.sv
// Core data-SRAM port bundle: request (en/we/addr/wdata) from the core, rdata back.
// master = core side, slave = memory responder side.
interface data_sram_responder_if;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word RAM plus MMIO (LED, switch, timer, IRQ), 1-cycle read latency.
// Optional timer block enabled by defining DATA_SRAM_RESP_TIMER_EN.
module data_sram_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
    input  logic                        clk,
    input  logic                        resetn,
    data_sram_responder_if.slave        bus,
    output logic [15:0]                 led,
    input  logic [7:0]                  switch_in,
    output logic                        timer_irq
);
    localparam logic [15:0] OFS_LED     = 16'h8000;
    localparam logic [15:0] OFS_SWITCH  = 16'h8004;
    localparam logic [15:0] OFS_TIMER   = 16'h8010;
    localparam logic [15:0] OFS_TIMECMP = 16'h8014;
    localparam logic [15:0] OFS_IRQSTAT = 16'h8018;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  we);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = we[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return res;
    endfunction

    logic [31:0]       r_mem [0:(2**RAM_AW)-1];
    logic [31:0]       r_rdata;
    logic [15:0]       r_led;
    logic [7:0]        r_sw_meta;
    logic [7:0]        r_sw_sync;
    logic              w_is_mmio;
    logic [15:0]       w_ofs;
    logic              w_wr;
    logic              w_rd;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_timer_q;
    logic [31:0]       w_timecmp_q;
    logic              w_irq_q;
    logic [1:0]        w_unused_addr;

    assign w_is_mmio     = (bus.sram_addr[31:16] == MMIO_BASE[31:16]);
    assign w_ofs         = bus.sram_addr[15:0];
    assign w_wr          = bus.sram_en && (bus.sram_we != 4'b0000);
    assign w_rd          = bus.sram_en && (bus.sram_we == 4'b0000);
    assign w_ram_idx     = bus.sram_addr[RAM_AW+1:2];
    assign w_unused_addr = bus.sram_addr[1:0];

    // RAM contents survive reset, so this array has no reset branch
    always_ff @(posedge clk) begin
        if (w_wr && !w_is_mmio) begin
            for (int b = 0; b < 4; b++)
                if (bus.sram_we[b])
                    r_mem[w_ram_idx][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
    end

`ifdef DATA_SRAM_RESP_TIMER_EN
    logic [31:0] r_timer;
    logic [31:0] r_timecmp;
    logic        r_irq;
    logic        w_irq_set;

    // Set is judged on the pre-edge timer value, and beats a simultaneous clear
    assign w_irq_set = (r_timer == r_timecmp) && (r_timecmp != 32'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer   <= 32'd0;
            r_timecmp <= 32'd0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && w_is_mmio && w_ofs == OFS_TIMER)
                r_timer <= lane_merge(r_timer, bus.sram_wdata, bus.sram_we);
            else
                r_timer <= r_timer + 32'd1;
            if (w_wr && w_is_mmio && w_ofs == OFS_TIMECMP)
                r_timecmp <= lane_merge(r_timecmp, bus.sram_wdata, bus.sram_we);
            if (w_irq_set)
                r_irq <= 1'b1;
            else if (w_wr && w_is_mmio && w_ofs == OFS_IRQSTAT)
                r_irq <= 1'b0;
        end
    end

    assign w_timer_q   = r_timer;
    assign w_timecmp_q = r_timecmp;
    assign w_irq_q     = r_irq;
`else
    assign w_timer_q   = 32'd0;
    assign w_timecmp_q = 32'd0;
    assign w_irq_q     = 1'b0;
`endif

    always_comb begin
        w_rd_word = 32'd0;
        if (w_is_mmio) begin
            case (w_ofs)
                OFS_LED:     w_rd_word = {16'd0, r_led};
                OFS_SWITCH:  w_rd_word = {24'd0, r_sw_sync};
                OFS_TIMER:   w_rd_word = w_timer_q;
                OFS_TIMECMP: w_rd_word = w_timecmp_q;
                OFS_IRQSTAT: w_rd_word = {31'd0, w_irq_q};
                default:     w_rd_word = 32'd0;
            endcase
        end else begin
            w_rd_word = r_mem[w_ram_idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata   <= 32'd0;
            r_led     <= 16'd0;
            r_sw_meta <= 8'd0;
            r_sw_sync <= 8'd0;
        end else begin
            r_sw_meta <= switch_in;
            r_sw_sync <= r_sw_meta;
            if (w_rd)
                r_rdata <= w_rd_word;
            if (w_wr && w_is_mmio && w_ofs == OFS_LED) begin
                if (bus.sram_we[0]) r_led[7:0]  <= bus.sram_wdata[7:0];
                if (bus.sram_we[1]) r_led[15:8] <= bus.sram_wdata[15:8];
            end
        end
    end

    assign bus.sram_rdata = r_rdata;
    assign led            = r_led;
    assign timer_irq      = w_irq_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder; timer checks follow DATA_SRAM_RESP_TIMER_EN.
module tb_data_sram_responder;
    logic        clk;
    logic        resetn;
    logic [15:0] led;
    logic [7:0]  switch_in;
    logic        timer_irq;
    int          errors;
    int          checks;

    data_sram_responder_if u_if ();

    data_sram_responder #(.RAM_AW(12), .MMIO_BASE(32'hBFAF_0000)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (u_if.slave),
        .led       (led),
        .switch_in (switch_in),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        u_if.sram_en    = 1'b1;
        u_if.sram_we    = we;
        u_if.sram_addr  = addr;
        u_if.sram_wdata = wdata;
        @(posedge clk);
        #1;
        u_if.sram_en = 1'b0;
        u_if.sram_we = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int irq_seen;
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        switch_in = 8'h00;
        u_if.sram_en = 1'b0;
        u_if.sram_we = 4'b0000;
        u_if.sram_addr = 32'd0;
        u_if.sram_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("reset_rdata", u_if.sram_rdata, 32'd0);
        check("reset_led", {16'd0, led}, 32'd0);
        check("reset_irq", {31'd0, timer_irq}, 32'd0);

        // RAM byte lanes
        access(4'b1111, 32'h0000_0100, 32'h1122_3344);
        access(4'b0010, 32'h0000_0100, 32'hAABB_CCDD);
        access(4'b0000, 32'h0000_0100, 32'd0);
        check("ram_bytelane", u_if.sram_rdata, 32'h1122_CC44);

        // Aliasing modulo 2**RAM_AW words
        access(4'b1111, 32'h0000_0004, 32'hDEAD_BEEF);
        access(4'b0000, 32'h0000_4004, 32'd0);
        check("ram_alias", u_if.sram_rdata, 32'hDEAD_BEEF);

        // Write then read on the very next cycle
        access(4'b1111, 32'h0000_0200, 32'hCAFE_F00D);
        access(4'b0000, 32'h0000_0200, 32'd0);
        check("ram_wr_then_rd", u_if.sram_rdata, 32'hCAFE_F00D);

        // rdata holds across a write and an idle cycle
        access(4'b1111, 32'h0000_0300, 32'h5555_AAAA);
        idle(1);
        check("rdata_hold", u_if.sram_rdata, 32'hCAFE_F00D);

        // LED
        access(4'b0001, 32'hBFAF_8000, 32'hFFFF_1234);
        check("led_lane0", {16'd0, led}, 32'h0000_0034);
        access(4'b0000, 32'hBFAF_8000, 32'd0);
        check("led_read", u_if.sram_rdata, 32'h0000_0034);
        access(4'b1111, 32'hBFAF_8000, 32'hFFFF_FFFF);
        access(4'b0000, 32'hBFAF_8000, 32'd0);
        check("led_upper_zero", u_if.sram_rdata, 32'h0000_FFFF);

        // MMIO write must not land in RAM (offset 0x8000 aliases RAM word 0x000)
        access(4'b1111, 32'h0000_0000, 32'h0BAD_0BAD);
        access(4'b1111, 32'hBFAF_8000, 32'h0000_1234);
        access(4'b0000, 32'h0000_0000, 32'd0);
        check("mmio_not_ram", u_if.sram_rdata, 32'h0BAD_0BAD);

        // Switch synchronizer
        @(negedge clk);
        switch_in = 8'hA5;
        idle(3);
        access(4'b0000, 32'hBFAF_8004, 32'd0);
        check("switch_read", u_if.sram_rdata, 32'h0000_00A5);

        // Unmapped MMIO reads zero
        access(4'b1111, 32'hBFAF_8020, 32'hFFFF_FFFF);
        access(4'b0000, 32'hBFAF_8020, 32'd0);
        check("unmapped_read", u_if.sram_rdata, 32'd0);

`ifdef DATA_SRAM_RESP_TIMER_EN
        // IRQ timing: TIMER=10 then TIMECMP=20, irq rises 11 edges after the TIMER write
        access(4'b1111, 32'hBFAF_8010, 32'd10);
        access(4'b1111, 32'hBFAF_8014, 32'd20);
        idle(9);
        check("irq_before", {31'd0, timer_irq}, 32'd0);
        idle(1);
        check("irq_rise", {31'd0, timer_irq}, 32'd1);
        access(4'b0000, 32'hBFAF_8018, 32'd0);
        check("irqstat_read", u_if.sram_rdata, 32'd1);
        access(4'b0001, 32'hBFAF_8018, 32'd0);
        check("irq_clear", {31'd0, timer_irq}, 32'd0);
        // Clear on the same edge as the compare match: set wins
        access(4'b1111, 32'hBFAF_8010, 32'd19);
        idle(1);
        check("irq_pre_match", {31'd0, timer_irq}, 32'd0);
        access(4'b1000, 32'hBFAF_8018, 32'd0);
        check("irq_set_wins", {31'd0, timer_irq}, 32'd1);

        access(4'b1111, 32'hBFAF_8010, 32'd100);
        access(4'b0000, 32'hBFAF_8010, 32'd0);
        check("timer_pre_incr", u_if.sram_rdata, 32'd100);
        access(4'b1111, 32'hBFAF_8010, 32'h1234_5678);
        access(4'b0001, 32'hBFAF_8010, 32'h0000_00FF);
        access(4'b0000, 32'hBFAF_8010, 32'd0);
        check("timer_lanes", u_if.sram_rdata, 32'h1234_56FF);
        access(4'b0000, 32'hBFAF_8014, 32'd0);
        check("timecmp_read", u_if.sram_rdata, 32'd20);
`else
        access(4'b1111, 32'hBFAF_8010, 32'd5);
        access(4'b0000, 32'hBFAF_8010, 32'd0);
        check("timer_off_read", u_if.sram_rdata, 32'd0);
        access(4'b1111, 32'hBFAF_8014, 32'd7);
        access(4'b0000, 32'hBFAF_8014, 32'd0);
        check("timecmp_off_read", u_if.sram_rdata, 32'd0);
        irq_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (timer_irq !== 1'b0) irq_seen++;
        end
        check("irq_off_1000", irq_seen, 32'd0);
`endif

        // Reset in the middle of a read
        access(4'b0000, 32'h0000_0100, 32'd0);
        check("pre_reset_rdata", u_if.sram_rdata, 32'h1122_CC44);
        @(negedge clk);
        u_if.sram_en   = 1'b1;
        u_if.sram_we   = 4'b0000;
        u_if.sram_addr = 32'hBFAF_8010;
        #2;
        resetn = 1'b0;
        #1;
        check("rst_rdata", u_if.sram_rdata, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_drop", u_if.sram_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        u_if.sram_en = 1'b0;
        check("rst_timer", u_if.sram_rdata, 32'd0);
        access(4'b0000, 32'h0000_0100, 32'd0);
        check("rst_ram_kept", u_if.sram_rdata, 32'h1122_CC44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
